// File: rtl/alu_mult_seq.sv
// Sequential 16x16->16 shift-and-add multiplier that issues every add, negate and shift to the shared ALU.
// Optional: define MULT_EARLY_TERM_EN to stop iterating once the remaining multiplier is zero.
module alu_mult_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  input  logic             signed_mul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ofl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  output logic             alu_inva,
  output logic             alu_invb,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl,
  input  logic             alu_zero,
  input  logic             alu_n
);

  localparam logic [2:0]       OP_ADD  = 3'h4;
  localparam logic [2:0]       OP_SLL  = 3'h1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_NEGA, S_NEGB, S_ADD, S_SHIF, S_NEGP, S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc, r_mc, r_mp, r_product;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg, r_sgn, r_ofl_s, r_busy, r_done, r_ofl;

  state_t           w_state_nxt, w_fin_state;
  logic [WIDTH-1:0] w_mp_sh;
  logic             w_ofl_s_nxt, w_ofl_fin;
  logic             w_unused;

  assign w_unused = ^{alu_zero, alu_n};

  // ENTRY is a pure decision: it picks the first working state for a multiplier value.
  function automatic state_t f_entry(input logic [WIDTH-1:0] mp, input state_t fin);
    if (EARLY && mp == '0) return fin;
    return mp[0] ? S_ADD : S_SHIF;
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_op   = OP_ADD;
    alu_inva = 1'b0;
    alu_invb = 1'b0;
    alu_sign = 1'b0;
    unique case (r_state)
      S_NEGA: begin alu_a = r_mc;  alu_inva = 1'b1; alu_cin = 1'b1; end
      S_NEGB: begin alu_a = r_mp;  alu_inva = 1'b1; alu_cin = 1'b1; end
      S_NEGP: begin alu_a = r_acc; alu_inva = 1'b1; alu_cin = 1'b1; end
      S_ADD:  begin alu_a = r_acc; alu_b = r_mc; end
      S_SHIF: begin alu_a = r_mc;  alu_b = WIDTH'(1); alu_op = OP_SLL; end
      default: ;
    endcase
  end

  always_comb begin
    w_mp_sh     = r_mp >> 1;
    w_fin_state = r_neg ? S_NEGP : S_DONE;
    w_ofl_s_nxt = r_ofl_s;
    if (r_state == S_ADD)  w_ofl_s_nxt = r_ofl_s | alu_ofl;
    if (r_state == S_SHIF) w_ofl_s_nxt = r_ofl_s | (r_mc[WIDTH-1] & (w_mp_sh != '0));
    // A magnitude of exactly 2^(WIDTH-1) is only representable when the result is negative.
    w_ofl_fin = w_ofl_s_nxt | (r_sgn & r_acc[WIDTH-1] & ~(r_neg & (r_acc == MIN_NEG)));

    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) begin
        if (signed_mul & mcand[WIDTH-1])       w_state_nxt = S_NEGA;
        else if (signed_mul & mplier[WIDTH-1]) w_state_nxt = S_NEGB;
        else                                   w_state_nxt = f_entry(mplier, S_DONE);
      end
      S_NEGA: w_state_nxt = (r_sgn & r_mp[WIDTH-1]) ? S_NEGB : f_entry(r_mp, w_fin_state);
      S_NEGB: w_state_nxt = f_entry(alu_out, w_fin_state);
      S_ADD:  w_state_nxt = S_SHIF;
      S_SHIF: begin
        if (r_cnt == CNT_W'(WIDTH-1) || (EARLY && w_mp_sh == '0)) w_state_nxt = w_fin_state;
        else w_state_nxt = w_mp_sh[0] ? S_ADD : S_SHIF;
      end
      S_NEGP: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mc      <= '0;
      r_mp      <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_sgn     <= 1'b0;
      r_ofl_s   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
      r_ofl     <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_ofl_s <= w_ofl_s_nxt;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_mc    <= mcand;
          r_mp    <= mplier;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_ofl_s <= 1'b0;
          r_sgn   <= signed_mul;
          r_neg   <= signed_mul & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
        end
        S_NEGA: r_mc  <= alu_out;
        S_NEGB: r_mp  <= alu_out;
        S_ADD:  r_acc <= alu_out;
        S_SHIF: begin
          r_mc  <= alu_out;
          r_mp  <= w_mp_sh;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_NEGP: r_acc <= alu_out;
        default: ;
      endcase
      // Product and overflow are captured on entry to DONE so they are valid alongside the pulse.
      if (w_state_nxt == S_DONE) begin
        if (r_state == S_IDLE) begin
          r_product <= '0;
          r_ofl     <= 1'b0;
        end else begin
          r_product <= (r_state == S_NEGP) ? alu_out : r_acc;
          r_ofl     <= w_ofl_fin;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign ofl     = r_ofl;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: supplies the shared ALU, keeps a transaction-level
// model of product/overflow/latency, and checks the DUT every cycle plus hand-computed vectors.
module tb_alu_mult_seq;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, signed_mul = 1'b0;
  logic [15:0] mcand = '0, mplier = '0;
  logic        busy, done, ofl, alu_cin, alu_inva, alu_invb, alu_sign;
  logic        alu_ofl, alu_zero, alu_n;
  logic [15:0] product, alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mult_seq dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .signed_mul(signed_mul), .busy(busy), .done(done), .product(product), .ofl(ofl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_zero(alu_zero), .alu_n(alu_n)
  );

  always #5 clk = ~clk;

  // Shared datapath ALU.
  always_comb begin
    logic [15:0] ea, eb;
    logic [16:0] sum;
    ea       = alu_inva ? ~alu_a : alu_a;
    eb       = alu_invb ? ~alu_b : alu_b;
    sum      = {1'b0, ea} + {1'b0, eb} + {16'h0, alu_cin};
    alu_out  = '0;
    alu_ofl  = 1'b0;
    if (alu_op == 3'h4) begin
      alu_out = sum[15:0];
      alu_ofl = sum[16];
    end else if (alu_op == 3'h1) begin
      alu_out = alu_a << alu_b[3:0];
    end
    alu_zero = (alu_out == '0);
    alu_n    = alu_out[15];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic longint ref_full(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint xa, xb;
    xa = s ? longint'($signed(a)) : longint'(a);
    xb = s ? longint'($signed(b)) : longint'(b);
    return xa * xb;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint f;
    f = ref_full(a, b, s);
    return f[15:0];
  endfunction

  function automatic logic ref_ofl(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint f;
    f = ref_full(a, b, s);
    return s ? (f < -32768 || f > 32767) : (f > 65535);
  endfunction

  // Working cycles: optional operand negations, one ADD per set magnitude bit, shifts, optional result negation.
  function automatic int ref_cycles(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] mb;
    int n, sh;
    mb = (s && b[15]) ? (~b + 16'd1) : b;
    n  = int'(s & a[15]) + int'(s & b[15]) + $countones(mb) + int'(s & (a[15] ^ b[15]));
`ifdef MULT_EARLY_TERM_EN
    sh = 0;
    for (int i = 0; i < 16; i++) if (mb[i]) sh = i + 1;
`else
    sh = 16;
`endif
    return n + sh;
  endfunction

  function automatic int lat(input int plain, input int early);
`ifdef MULT_EARLY_TERM_EN
    return early;
`else
    return plain;
`endif
  endfunction

  logic        m_active = 1'b0, m_ofl_q = 1'b0, m_ofl_nxt = 1'b0;
  int          m_k = 0, m_lat = 0;
  logic [15:0] m_prod_q = '0, m_prod_nxt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active   <= 1'b0;
      m_k        <= 0;
      m_lat      <= 0;
      m_prod_q   <= '0;
      m_ofl_q    <= 1'b0;
      m_prod_nxt <= '0;
      m_ofl_nxt  <= 1'b0;
    end else if (m_active) begin
      if (m_k == m_lat) m_active <= 1'b0;
      else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_lat) begin
          m_prod_q <= m_prod_nxt;
          m_ofl_q  <= m_ofl_nxt;
        end
      end
    end else if (start) begin
      m_active   <= 1'b1;
      m_k        <= 0;
      m_lat      <= ref_cycles(mcand, mplier, signed_mul);
      m_prod_nxt <= ref_prod(mcand, mplier, signed_mul);
      m_ofl_nxt  <= ref_ofl(mcand, mplier, signed_mul);
      if (ref_cycles(mcand, mplier, signed_mul) == 0) begin
        m_prod_q <= ref_prod(mcand, mplier, signed_mul);
        m_ofl_q  <= ref_ofl(mcand, mplier, signed_mul);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc busy", busy, m_active);
      check("cyc done", done, m_active && m_k == m_lat);
      check("cyc product", product, m_prod_q);
      check("cyc ofl", ofl, m_ofl_q);
      check("cyc alu_sign", alu_sign, 1'b0);
      if (!m_active || m_k == m_lat)
        check("cyc idle alu cmd", {alu_op, alu_a, alu_b, alu_cin, alu_inva, alu_invb},
              {3'h4, 32'h0, 3'b000});
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] xp, input logic xo, input int xc, input string nm);
    int   cyc;
    logic seen;
    @(negedge clk);
    mcand = a; mplier = b; signed_mul = s; start = 1'b1;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
    end
    check({nm, " done seen"}, seen, 1'b1);
    check({nm, " done cycle"}, cyc, xc);
    check({nm, " product"}, product, xp);
    check({nm, " ofl"}, ofl, xo);
  endtask

  initial begin
    int ndone;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset product", product, 16'h0);
    check("reset ofl", ofl, 1'b0);
    check("reset alu_op", alu_op, 3'h4);

    run_op(16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, lat(19, 6),  "u 3x5");
    run_op(16'h0005, 16'h0003, 1'b0, 16'h000F, 1'b0, lat(19, 5),  "u 5x3");
    run_op(16'hFFFD, 16'h0005, 1'b1, 16'hFFF1, 1'b0, lat(21, 8),  "s -3x5");
    run_op(16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, lat(18, 11), "u 256x256");
    run_op(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, lat(20, 5),  "s min x1");
    run_op(16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, lat(17, 1),  "u x0");
    run_op(16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, lat(33, 33), "u 0xffff");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 1'b0, lat(20, 5),  "s -1x-1");
    run_op(16'h0100, 16'hFF00, 1'b1, 16'h0000, 1'b1, lat(20, 13), "s 256x-256");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b1, lat(33, 33), "u max x max");
    run_op(16'hFF80, 16'h0100, 1'b1, 16'h8000, 1'b0, lat(20, 13), "s -128x256");
    run_op(16'h0080, 16'h0100, 1'b1, 16'h8000, 1'b1, lat(18, 11), "s 128x256");
    run_op(16'h4000, 16'h0002, 1'b1, 16'h8000, 1'b1, lat(18, 4),  "s 4000x2");

    // A second start while busy must be ignored.
    @(negedge clk);
    mcand = 16'h0003; mplier = 16'h0005; signed_mul = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    mcand = 16'h00FF; mplier = 16'h00FF; start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
    end
    check("busy start done count", ndone, 1);
    check("busy start product", product, 16'h000F);
    check("busy start ofl", ofl, 1'b0);

    // Reset in the middle of the shift phase clears outputs without a clock edge.
    run_op(16'h4000, 16'h0002, 1'b1, 16'h8000, 1'b1, lat(18, 4), "s 4000x2 pre-reset");
    @(negedge clk);
    mcand = 16'h0007; mplier = 16'h0009; signed_mul = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid reset busy", busy, 1'b0);
    check("mid reset done", done, 1'b0);
    check("mid reset product", product, 16'h0);
    check("mid reset ofl", ofl, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0007, 16'h0009, 1'b0, 16'h003F, 1'b0, lat(19, 7), "u 7x9 after reset");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
